// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of the 5-stage MIPS32 pipeline. It takes the EX/MEM
// register outputs and performs word loads and stores over a req/ack data bus.
// While an access is outstanding it stalls the upstream pipeline. It also
// holds the MEM/WB pipeline register that feeds write-back.
//
// Ports
//   clk, reset               clock; asynchronous active-high reset
//   MEM_*                    instruction fields from EX/MEM
//   dbus_req/we/addr/wdata   registered bus request outputs
//   dbus_rdata, dbus_ack     bus response (rdata valid while ack=1)
//   mem_stall                combinational hold for PC, IF/ID, ID/EX, EX/MEM
//   mem_err                  sticky misaligned-access / bus-timeout flag
//   WB_*                     MEM/WB register contents
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MEM_PC_p4,
    input  logic [31:0] MEM_alu_out,
    input  logic [31:0] MEM_rt_data,
    input  logic [4:0]  MEM_Rd,
    input  logic [1:0]  MEM_MemToReg,
    input  logic        MEM_MemWrite,
    input  logic        MEM_MemRead,
    input  logic        MEM_RegWrite,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        mem_stall,
    output logic        mem_err,
    output logic [31:0] WB_PC_p4,
    output logic [31:0] WB_alu_out,
    output logic [31:0] WB_mem_data,
    output logic [4:0]  WB_Rd,
    output logic [1:0]  WB_MemToReg,
    output logic        WB_RegWrite
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Last counter value before the access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] wb_pc_q, wb_pc_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [31:0] wb_mem_q, wb_mem_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [1:0]  wb_m2r_q, wb_m2r_d;
    logic        wb_rw_q, wb_rw_d;

    logic access;
    logic misaligned;
    logic capture;

    assign access     = MEM_MemRead | MEM_MemWrite;
    assign misaligned = access & (MEM_alu_out[1:0] != 2'b00);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        mem_stall = 1'b0;
        capture   = 1'b0;
        wb_mem_d  = 32'd0;

        unique case (state_q)
            IDLE: begin
                if (access && !misaligned) begin
                    mem_stall = 1'b1;
                    state_d   = BUSY;
                    req_d     = 1'b1;
                    we_d      = MEM_MemWrite;
                    addr_d    = MEM_alu_out;
                    wdata_d   = MEM_rt_data;
                    cnt_d     = 8'd0;
                end else begin
                    // Misaligned accesses retire without touching the bus,
                    // so a misaligned store is simply dropped.
                    capture = 1'b1;
                    if (misaligned) begin
                        err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (dbus_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    capture = 1'b1;
                    if (MEM_MemRead) begin
                        wb_mem_d = dbus_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: retire the instruction with zero data.
                    state_d = IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    capture = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // While stalled MEM/WB takes a bubble (all fields zero).
        if (capture) begin
            wb_pc_d  = MEM_PC_p4;
            wb_alu_d = MEM_alu_out;
            wb_rd_d  = MEM_Rd;
            wb_m2r_d = MEM_MemToReg;
            wb_rw_d  = MEM_RegWrite;
        end else begin
            wb_pc_d  = 32'd0;
            wb_alu_d = 32'd0;
            wb_rd_d  = 5'd0;
            wb_m2r_d = 2'd0;
            wb_rw_d  = 1'b0;
            wb_mem_d = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
            wb_pc_q  <= 32'd0;
            wb_alu_q <= 32'd0;
            wb_mem_q <= 32'd0;
            wb_rd_q  <= 5'd0;
            wb_m2r_q <= 2'd0;
            wb_rw_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            wb_pc_q  <= wb_pc_d;
            wb_alu_q <= wb_alu_d;
            wb_mem_q <= wb_mem_d;
            wb_rd_q  <= wb_rd_d;
            wb_m2r_q <= wb_m2r_d;
            wb_rw_q  <= wb_rw_d;
        end
    end

    assign dbus_req    = req_q;
    assign dbus_we     = we_q;
    assign dbus_addr   = addr_q;
    assign dbus_wdata  = wdata_q;
    assign mem_err     = err_q;
    assign WB_PC_p4    = wb_pc_q;
    assign WB_alu_out  = wb_alu_q;
    assign WB_mem_data = wb_mem_q;
    assign WB_Rd       = wb_rd_q;
    assign WB_MemToReg = wb_m2r_q;
    assign WB_RegWrite = wb_rw_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Directed bench for mem_stage (TIMEOUT_CYC = 4). Inputs change 1 ns after a
// rising edge; combinational outputs are sampled 1 ns later and registered
// outputs 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] MEM_PC_p4, MEM_alu_out, MEM_rt_data;
    logic [4:0]  MEM_Rd;
    logic [1:0]  MEM_MemToReg;
    logic        MEM_MemWrite, MEM_MemRead, MEM_RegWrite;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic        dbus_ack;
    logic        mem_stall, mem_err;
    logic [31:0] WB_PC_p4, WB_alu_out, WB_mem_data;
    logic [4:0]  WB_Rd;
    logic [1:0]  WB_MemToReg;
    logic        WB_RegWrite;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.TIMEOUT_CYC(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .MEM_PC_p4    (MEM_PC_p4),
        .MEM_alu_out  (MEM_alu_out),
        .MEM_rt_data  (MEM_rt_data),
        .MEM_Rd       (MEM_Rd),
        .MEM_MemToReg (MEM_MemToReg),
        .MEM_MemWrite (MEM_MemWrite),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_RegWrite (MEM_RegWrite),
        .dbus_req     (dbus_req),
        .dbus_we      (dbus_we),
        .dbus_addr    (dbus_addr),
        .dbus_wdata   (dbus_wdata),
        .dbus_rdata   (dbus_rdata),
        .dbus_ack     (dbus_ack),
        .mem_stall    (mem_stall),
        .mem_err      (mem_err),
        .WB_PC_p4     (WB_PC_p4),
        .WB_alu_out   (WB_alu_out),
        .WB_mem_data  (WB_mem_data),
        .WB_Rd        (WB_Rd),
        .WB_MemToReg  (WB_MemToReg),
        .WB_RegWrite  (WB_RegWrite)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rt,
                             input logic [4:0] rd, input logic [1:0] m2r,
                             input logic mw, input logic mr, input logic rw);
        MEM_PC_p4    = pc;
        MEM_alu_out  = alu;
        MEM_rt_data  = rt;
        MEM_Rd       = rd;
        MEM_MemToReg = m2r;
        MEM_MemWrite = mw;
        MEM_MemRead  = mr;
        MEM_RegWrite = rw;
    endtask

    task automatic check_wb_zero(input string tag);
        check_eq({tag, "_wb_pc"},  WB_PC_p4, 32'd0);
        check_eq({tag, "_wb_alu"}, WB_alu_out, 32'd0);
        check_eq({tag, "_wb_mem"}, WB_mem_data, 32'd0);
        check_eq({tag, "_wb_rd"},  32'(WB_Rd), 32'd0);
        check_eq({tag, "_wb_m2r"}, 32'(WB_MemToReg), 32'd0);
        check_eq({tag, "_wb_rw"},  32'(WB_RegWrite), 32'd0);
    endtask

    initial begin
        int  reqc;
        int  stc;
        bit  done;

        reset      = 1'b1;
        dbus_ack   = 1'b0;
        dbus_rdata = 32'd0;
        set_instr(32'd0, 32'd0, 32'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        // Reset state
        check_eq("rst_req", 32'(dbus_req), 32'd0);
        check_eq("rst_we", 32'(dbus_we), 32'd0);
        check_eq("rst_addr", dbus_addr, 32'd0);
        check_eq("rst_wdata", dbus_wdata, 32'd0);
        check_eq("rst_err", 32'(mem_err), 32'd0);
        check_eq("rst_stall", 32'(mem_stall), 32'd0);
        check_wb_zero("rst");
        step();
        step();
        reset = 1'b0;

        // ALU op pass-through
        set_instr(32'h40, 32'h1234, 32'h0, 5'd5, 2'b00, 1'b0, 1'b0, 1'b1);
        #1;
        check_eq("alu_stall", 32'(mem_stall), 32'd0);
        check_eq("alu_req0", 32'(dbus_req), 32'd0);
        step();
        check_eq("alu_wb_alu", WB_alu_out, 32'h1234);
        check_eq("alu_wb_rd", 32'(WB_Rd), 32'd5);
        check_eq("alu_wb_rw", 32'(WB_RegWrite), 32'd1);
        check_eq("alu_wb_pc", WB_PC_p4, 32'h40);
        check_eq("alu_wb_mem", WB_mem_data, 32'd0);
        check_eq("alu_req1", 32'(dbus_req), 32'd0);

        // Load, ack in first BUSY cycle
        set_instr(32'h44, 32'h100, 32'h0, 5'd8, 2'b01, 1'b0, 1'b1, 1'b1);
        #1;
        check_eq("ld_stall_idle", 32'(mem_stall), 32'd1);
        step();
        check_eq("ld_req", 32'(dbus_req), 32'd1);
        check_eq("ld_we", 32'(dbus_we), 32'd0);
        check_eq("ld_addr", dbus_addr, 32'h100);
        check_eq("ld_bubble_rw", 32'(WB_RegWrite), 32'd0);
        check_eq("ld_bubble_rd", 32'(WB_Rd), 32'd0);
        dbus_ack   = 1'b1;
        dbus_rdata = 32'hDEADBEEF;
        #1;
        check_eq("ld_stall_ack", 32'(mem_stall), 32'd0);
        step();
        dbus_ack   = 1'b0;
        dbus_rdata = 32'h0;
        check_eq("ld_wb_mem", WB_mem_data, 32'hDEADBEEF);
        check_eq("ld_wb_rd", 32'(WB_Rd), 32'd8);
        check_eq("ld_wb_rw", 32'(WB_RegWrite), 32'd1);
        check_eq("ld_wb_m2r", 32'(WB_MemToReg), 32'd1);
        check_eq("ld_req_drop", 32'(dbus_req), 32'd0);

        // Store, ack in 3rd BUSY cycle
        set_instr(32'h48, 32'h200, 32'hCAFEF00D, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        #1;
        check_eq("st_stall_idle", 32'(mem_stall), 32'd1);
        step();
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("st_req_%0d", k), 32'(dbus_req), 32'd1);
            check_eq($sformatf("st_we_%0d", k), 32'(dbus_we), 32'd1);
            check_eq($sformatf("st_addr_%0d", k), dbus_addr, 32'h200);
            check_eq($sformatf("st_wdata_%0d", k), dbus_wdata, 32'hCAFEF00D);
            if (k == 2) dbus_ack = 1'b1;
            #1;
            check_eq($sformatf("st_stall_%0d", k), 32'(mem_stall), (k == 2) ? 32'd0 : 32'd1);
            step();
        end
        dbus_ack = 1'b0;
        check_eq("st_req_drop", 32'(dbus_req), 32'd0);
        check_eq("st_wb_mem", WB_mem_data, 32'd0);
        check_eq("st_wb_pc", WB_PC_p4, 32'h48);
        check_eq("st_err", 32'(mem_err), 32'd0);

        // Misaligned load
        set_instr(32'h4C, 32'h102, 32'h0, 5'd9, 2'b01, 1'b0, 1'b1, 1'b1);
        #1;
        check_eq("mis_stall", 32'(mem_stall), 32'd0);
        step();
        check_eq("mis_req", 32'(dbus_req), 32'd0);
        check_eq("mis_err", 32'(mem_err), 32'd1);
        check_eq("mis_wb_mem", WB_mem_data, 32'd0);
        check_eq("mis_wb_rd", 32'(WB_Rd), 32'd9);
        check_eq("mis_wb_rw", 32'(WB_RegWrite), 32'd1);
        check_eq("mis_wb_alu", WB_alu_out, 32'h102);
        set_instr(32'h50, 32'h7, 32'h0, 5'd1, 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("mis_err_sticky", 32'(mem_err), 32'd1);
        check_eq("mis_next_req", 32'(dbus_req), 32'd0);

        // Clear the sticky error so the timeout can set it afresh
        reset = 1'b1;
        #1;
        check_eq("rst2_err", 32'(mem_err), 32'd0);
        step();
        reset = 1'b0;

        // Timeout (TIMEOUT_CYC = 4), ack never asserted
        set_instr(32'h54, 32'h300, 32'h0, 5'd10, 2'b01, 1'b0, 1'b1, 1'b1);
        #1;
        reqc = 0;
        stc  = 0;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            reqc += int'(dbus_req);
            stc  += int'(mem_stall);
            if (!mem_stall) done = 1'b1;
            step();
            #1;
        end
        check_eq("to_done", 32'(done), 32'd1);
        check_eq("to_req_cycles", 32'(reqc), 32'd4);
        check_eq("to_stall_cycles", 32'(stc), 32'd4);
        check_eq("to_req_drop", 32'(dbus_req), 32'd0);
        check_eq("to_err", 32'(mem_err), 32'd1);
        check_eq("to_wb_mem", WB_mem_data, 32'd0);
        check_eq("to_wb_rd", 32'(WB_Rd), 32'd10);
        check_eq("to_wb_rw", 32'(WB_RegWrite), 32'd1);
        set_instr(32'h58, 32'h55, 32'h0, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1);
        #1;
        check_eq("to_next_stall", 32'(mem_stall), 32'd0);
        step();
        check_eq("to_next_wb_alu", WB_alu_out, 32'h55);
        check_eq("to_next_wb_rd", 32'(WB_Rd), 32'd3);
        check_eq("to_next_req", 32'(dbus_req), 32'd0);

        // Reset during the 2nd BUSY cycle
        set_instr(32'h5C, 32'h400, 32'h0, 5'd11, 2'b01, 1'b0, 1'b1, 1'b1);
        step();
        step();
        check_eq("rm_req_busy", 32'(dbus_req), 32'd1);
        check_eq("rm_addr_busy", dbus_addr, 32'h400);
        reset = 1'b1;
        #1;
        check_eq("rm_req", 32'(dbus_req), 32'd0);
        check_eq("rm_addr", dbus_addr, 32'd0);
        check_eq("rm_err", 32'(mem_err), 32'd0);
        check_wb_zero("rm");
        set_instr(32'd0, 32'd0, 32'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h12345678;
        #1;
        check_eq("late_ack_stall", 32'(mem_stall), 32'd0);
        step();
        dbus_ack = 1'b0;
        check_eq("late_ack_req", 32'(dbus_req), 32'd0);
        check_eq("late_ack_wb_mem", WB_mem_data, 32'd0);
        check_eq("late_ack_wb_rw", 32'(WB_RegWrite), 32'd0);
        check_eq("late_ack_err", 32'(mem_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
